// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop sync, 3-sample majority vote at mid-bit, and a
// single-entry holding register with valid / framing-error / overrun flags.
module uart_rx #(
  parameter int BIT_CLKS = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_ack,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);
  localparam int CW = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] HALF_C = CW'(BIT_CLKS / 2);
  localparam logic [CW-1:0] LAST_C = CW'(BIT_CLKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

  state_t          r_state;
  logic [1:0]      r_sync;
  logic [2:0]      r_hist;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bitn;
  logic [7:0]      r_sr;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_ferr;
  logic            r_ovrn;

  logic w_rx_s, w_maj, w_load;

  assign w_rx_s = r_sync[1];
  assign w_maj  = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
  // The stop-bit sample is the only point where a byte enters the holding register.
  assign w_load = (r_state == S_STOP) && (r_cnt == LAST_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= 2'b11;
      r_hist <= 3'b111;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_hist <= {r_hist[1:0], w_rx_s};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_sr    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovrn  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == HALF_C) begin
            r_cnt <= '0;
            if (!w_maj) begin
              r_state <= S_DATA;
              r_bitn  <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == LAST_C) begin
            r_sr   <= {w_maj, r_sr[7:1]};
            r_cnt  <= '0;
            r_bitn <= r_bitn + 3'd1;
            if (r_bitn == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == LAST_C) begin
            r_cnt   <= '0;
            r_state <= w_maj ? S_IDLE : S_BRK;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_BRK: begin
          // A held-low line must return high before another start is accepted.
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_load) begin
        if (!r_valid || rd_ack) begin
          r_data  <= r_sr;
          r_ferr  <= ~w_maj;
          r_valid <= 1'b1;
        end else begin
          r_ovrn <= 1'b1;
        end
      end else if (rd_ack && r_valid) begin
        r_valid <= 1'b0;
        r_ovrn  <= 1'b0;
      end
    end
  end

  assign data_out    = r_data;
  assign valid       = r_valid;
  assign framing_err = r_ferr;
  assign overrun     = r_ovrn;
  assign busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clks/bit; inputs change on negedge, outputs
// are checked on negedge.
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_ack;
  logic [7:0] data_out;
  logic       valid, framing_err, overrun, busy;

  int tests = 0;
  int fails = 0;

  uart_rx #(.BIT_CLKS(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_ack(rd_ack),
    .data_out(data_out), .valid(valid), .framing_err(framing_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    @(negedge clk);
  endtask

  // Full frame: start, 8 data bits LSB first, stop. Optional 1-clk glitch
  // mid data bit, optional rd_ack on the exact stop-sample (load) cycle.
  task automatic send(input logic [7:0] b, input logic stop, input bit glitch, input bit ack_ld);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 16; i++) begin
        rx     = (glitch && k >= 1 && k <= 8 && i == 8) ? ~f[k] : f[k];
        rd_ack = ack_ld && k == 9 && i == 11;
        @(negedge clk);
      end
    end
    rd_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_data", data_out, 8'h00);
    check("rst_valid", {7'd0, valid}, 8'd0);
    check("rst_ferr", {7'd0, framing_err}, 8'd0);
    check("rst_ovrn", {7'd0, overrun}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    idle(4);

    send(8'h55, 1'b1, 0, 0);
    check("b55_data", data_out, 8'h55);
    check("b55_valid", {7'd0, valid}, 8'd1);
    check("b55_ferr", {7'd0, framing_err}, 8'd0);
    check("b55_ovrn", {7'd0, overrun}, 8'd0);
    ack();
    check("b55_ackvalid", {7'd0, valid}, 8'd0);
    send(8'hA3, 1'b1, 0, 0);
    check("bA3_data", data_out, 8'hA3);
    check("bA3_valid", {7'd0, valid}, 8'd1);
    check("bA3_ovrn", {7'd0, overrun}, 8'd0);
    ack();
    check("bA3_ackvalid", {7'd0, valid}, 8'd0);

    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(24);
    check("glitch_valid", {7'd0, valid}, 8'd0);
    check("glitch_busy", {7'd0, busy}, 8'd0);
    check("glitch_data", data_out, 8'hA3);
    check("glitch_ferr", {7'd0, framing_err}, 8'd0);

    send(8'h3C, 1'b0, 0, 0);
    check("brk_busy", {7'd0, busy}, 8'd1);
    repeat (32) @(negedge clk);
    idle(20);
    check("brk_data", data_out, 8'h3C);
    check("brk_ferr", {7'd0, framing_err}, 8'd1);
    check("brk_valid", {7'd0, valid}, 8'd1);
    check("brk_ovrn", {7'd0, overrun}, 8'd0);
    check("brk_busy_end", {7'd0, busy}, 8'd0);
    ack();
    check("brk_ackvalid", {7'd0, valid}, 8'd0);
    check("brk_ackferr", {7'd0, framing_err}, 8'd1);

    send(8'h11, 1'b1, 0, 0);
    send(8'h22, 1'b1, 0, 0);
    idle(2);
    check("ov_data", data_out, 8'h11);
    check("ov_ovrn", {7'd0, overrun}, 8'd1);
    check("ov_valid", {7'd0, valid}, 8'd1);
    check("ov_ferr", {7'd0, framing_err}, 8'd0);
    ack();
    check("ov_ackvalid", {7'd0, valid}, 8'd0);
    check("ov_ackovrn", {7'd0, overrun}, 8'd0);
    check("ov_ackdata", data_out, 8'h11);

    send(8'h5A, 1'b1, 0, 0);
    send(8'h77, 1'b1, 0, 1);
    check("ackld_valid", {7'd0, valid}, 8'd1);
    check("ackld_data", data_out, 8'h77);
    check("ackld_ovrn", {7'd0, overrun}, 8'd0);

    // Abort mid bit 4 while the holding register is still full.
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (4 * 16 + 8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_data", data_out, 8'h00);
    check("mrst_valid", {7'd0, valid}, 8'd0);
    check("mrst_ferr", {7'd0, framing_err}, 8'd0);
    check("mrst_ovrn", {7'd0, overrun}, 8'd0);
    check("mrst_busy", {7'd0, busy}, 8'd0);
    idle(40);
    check("mrst_idle_valid", {7'd0, valid}, 8'd0);
    send(8'hE1, 1'b1, 0, 0);
    check("bE1_data", data_out, 8'hE1);
    check("bE1_valid", {7'd0, valid}, 8'd1);
    check("bE1_ferr", {7'd0, framing_err}, 8'd0);
    ack();

    send(8'hB4, 1'b1, 1, 0);
    check("gl_data", data_out, 8'hB4);
    check("gl_valid", {7'd0, valid}, 8'd1);
    check("gl_ferr", {7'd0, framing_err}, 8'd0);
    check("gl_ovrn", {7'd0, overrun}, 8'd0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
